// File: rtl/effects_chain_sequencer_pkg.sv
// Shared definitions for the effects chain sequencer: FSM states, stage
// indices and default sizing.
package effects_chain_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_WAIT   = 2'd2
    } seq_state_t;

    localparam int unsigned STAGE_DELAY       = 0;
    localparam int unsigned STAGE_COMPRESSION = 1;
    localparam int unsigned STAGE_LIMITER     = 2;

    localparam int unsigned DEFAULT_WIDTH      = 12;
    localparam int unsigned DEFAULT_NUM_STAGES = 3;
    localparam int unsigned DEFAULT_TIMEOUT    = 1024;
    localparam int unsigned OVERRUN_W          = 8;

    // Width of a timer counting 0 .. cycles-1 (never narrower than one bit).
    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/effects_chain_sequencer_watchdog.sv
// Per-stage hang detector: counts WAIT cycles and flags the final allowed one.
module stage_watchdog
    import effects_chain_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int unsigned TW = timer_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            timer <= '0;
        end else if (count && !expired) begin
            timer <= timer + 1'b1;
        end
    end

    assign expired = (timer == LAST);

endmodule

// File: rtl/effects_chain_sequencer.sv
// Runs each captured sample through the enabled effect stages in order and
// presents the result with a one-cycle ready pulse.
module effects_chain_sequencer
    import effects_chain_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned NUM_STAGES     = DEFAULT_NUM_STAGES,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        playback,
    input  logic                        new_sample_ready,
    input  logic [WIDTH-1:0]            samples_in,
    input  logic [NUM_STAGES-1:0]       stage_enable,
    output logic [NUM_STAGES-1:0]       stage_start,
    output logic [WIDTH-1:0]            stage_sample,
    input  logic [NUM_STAGES-1:0]       stage_done,
    input  logic [NUM_STAGES*WIDTH-1:0] stage_result,
    input  logic                        clear_status,
    output logic [WIDTH-1:0]            sample_out,
    output logic                        sample_ready,
    output logic                        busy,
    output logic [NUM_STAGES-1:0]       stage_fault,
    output logic [OVERRUN_W-1:0]        overrun_count
);

    localparam int unsigned IW = $clog2(NUM_STAGES + 1);

    seq_state_t             state, state_next;
    logic [IW-1:0]          idx, idx_next;
    logic [WIDTH-1:0]       work, work_next;
    logic [NUM_STAGES-1:0]  start_next;
    logic [WIDTH-1:0]       out_next;
    logic                   ready_next;
    logic [NUM_STAGES-1:0]  fault_set;

    logic                   cur_enable;
    logic                   cur_done;
    logic [WIDTH-1:0]       cur_result;
    logic [NUM_STAGES-1:0]  cur_onehot;
    logic                   at_end;
    logic                   expired;
    logic                   overrun_event;

    stage_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (state != ST_WAIT),
        .count  (state == ST_WAIT),
        .expired(expired)
    );

    // Decode the current stage by comparison so idx == NUM_STAGES never indexes out of range.
    always_comb begin
        cur_enable = 1'b0;
        cur_done   = 1'b0;
        cur_result = '0;
        cur_onehot = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (idx == IW'(i)) begin
                cur_enable    = stage_enable[i];
                cur_done      = stage_done[i];
                cur_result    = stage_result[i*WIDTH +: WIDTH];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    assign at_end = (idx == IW'(NUM_STAGES));

    always_comb begin
        state_next = state;
        idx_next   = idx;
        work_next  = work;
        start_next = '0;
        out_next   = sample_out;
        ready_next = 1'b0;
        fault_set  = '0;
        unique case (state)
            ST_IDLE: begin
                if (playback && new_sample_ready) begin
                    work_next  = samples_in;
                    idx_next   = '0;
                    state_next = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (at_end) begin
                    out_next   = work;
                    ready_next = 1'b1;
                    state_next = ST_IDLE;
                end else if (cur_enable) begin
                    start_next = cur_onehot;
                    state_next = ST_WAIT;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            ST_WAIT: begin
                // done takes priority over an expiring timer
                if (cur_done) begin
                    work_next  = cur_result;
                    idx_next   = idx + 1'b1;
                    state_next = ST_SELECT;
                end else if (expired) begin
                    fault_set  = cur_onehot;
                    idx_next   = idx + 1'b1;
                    state_next = ST_SELECT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign overrun_event = playback && new_sample_ready && (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            idx           <= '0;
            work          <= '0;
            stage_start   <= '0;
            sample_out    <= '0;
            sample_ready  <= 1'b0;
            stage_fault   <= '0;
            overrun_count <= '0;
        end else begin
            state        <= state_next;
            idx          <= idx_next;
            work         <= work_next;
            stage_start  <= start_next;
            sample_out   <= out_next;
            sample_ready <= ready_next;
            if (clear_status) begin
                stage_fault   <= '0;
                overrun_count <= '0;
            end else begin
                stage_fault <= stage_fault | fault_set;
                if (overrun_event && (overrun_count != '1)) begin
                    overrun_count <= overrun_count + 1'b1;
                end
            end
        end
    end

    assign stage_sample = work;
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_effects_chain_sequencer.sv
// Directed bench for effects_chain_sequencer with a behavioural stage responder.
module tb_effects_chain_sequencer;

    localparam int W  = 12;
    localparam int N  = 3;
    localparam int TO = 512;

    logic             clock;
    logic             reset;
    logic             playback;
    logic             new_sample_ready;
    logic [W-1:0]     samples_in;
    logic [N-1:0]     stage_enable;
    logic [N-1:0]     stage_start;
    logic [W-1:0]     stage_sample;
    logic [N-1:0]     stage_done;
    logic [N*W-1:0]   stage_result;
    logic             clear_status;
    logic [W-1:0]     sample_out;
    logic             sample_ready;
    logic             busy;
    logic [N-1:0]     stage_fault;
    logic [7:0]       overrun_count;

    effects_chain_sequencer #(
        .WIDTH         (W),
        .NUM_STAGES    (N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .playback        (playback),
        .new_sample_ready(new_sample_ready),
        .samples_in      (samples_in),
        .stage_enable    (stage_enable),
        .stage_start     (stage_start),
        .stage_sample    (stage_sample),
        .stage_done      (stage_done),
        .stage_result    (stage_result),
        .clear_status    (clear_status),
        .sample_out      (sample_out),
        .sample_ready    (sample_ready),
        .busy            (busy),
        .stage_fault     (stage_fault),
        .overrun_count   (overrun_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int t0 = 0;

    // Responder configuration: delay < 0 means the stage never answers.
    int           resp_delay[N];
    int           op_mode;
    logic [W-1:0] resp_const[N];
    logic [N-1:0] force_done;
    int           start_log[$];
    int           start_cyc_log[$];
    int           seen_sample[N];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] stage_op(input int i, input logic [W-1:0] x);
        if (op_mode == 1) begin
            case (i)
                0:       return x + 1'b1;
                1:       return x << 1;
                default: return x - 3;
            endcase
        end
        return resp_const[i];
    endfunction

    initial begin : responder
        bit           pending;
        int           cnt;
        int           pidx;
        logic [W-1:0] pres;
        pending = 0;
        cnt = 0;
        pidx = 0;
        pres = '0;
        stage_done = '0;
        stage_result = '0;
        forever begin
            @(negedge clock);
            stage_done = force_done;
            if (pending) begin
                if (cnt == 0) begin
                    stage_done[pidx] = 1'b1;
                    stage_result[pidx*W +: W] = pres;
                    pending = 0;
                end else begin
                    cnt--;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (stage_start[i]) begin
                    start_log.push_back(i);
                    start_cyc_log.push_back(cyc - t0);
                    seen_sample[i] = int'($signed(stage_sample));
                    if (resp_delay[i] >= 0) begin
                        pres = stage_op(i, stage_sample);
                        pidx = i;
                        if (resp_delay[i] == 0) begin
                            stage_done[i] = 1'b1;
                            stage_result[i*W +: W] = pres;
                        end else begin
                            pending = 1;
                            cnt = resp_delay[i] - 1;
                        end
                    end
                end
            end
        end
    end

    task automatic configure(input logic [N-1:0] en, input int d0, input int d1, input int d2, input int mode);
        stage_enable = en;
        resp_delay[0] = d0;
        resp_delay[1] = d1;
        resp_delay[2] = d2;
        op_mode = mode;
        start_log.delete();
        start_cyc_log.delete();
    endtask

    task automatic send(input logic signed [W-1:0] s);
        @(negedge clock);
        samples_in = s;
        new_sample_ready = 1'b1;
        t0 = cyc;
        @(negedge clock);
        new_sample_ready = 1'b0;
    endtask

    task automatic wait_ready(input int bound, output int lat, output int val);
        lat = -1;
        val = 0;
        for (int k = 0; k < bound; k++) begin
            if (sample_ready) begin
                lat = cyc - t0;
                val = int'($signed(sample_out));
                return;
            end
            @(negedge clock);
        end
        check("ready_timeout", 0, 1);
    endtask

    initial begin : main
        int lat;
        int val;
        int pulses;
        reset = 1'b1;
        playback = 1'b1;
        new_sample_ready = 1'b0;
        samples_in = '0;
        clear_status = 1'b0;
        force_done = '0;
        for (int i = 0; i < N; i++) resp_const[i] = '0;
        configure(3'b000, -1, -1, -1, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_out", int'(sample_out), 0);
        check("rst_ready", int'(sample_ready), 0);
        check("rst_start", int'(stage_start), 0);
        check("rst_fault", int'(stage_fault), 0);
        check("rst_overrun", int'(overrun_count), 0);

        playback = 1'b0;
        send(12'sd33);
        check("nopb_busy", int'(busy), 0);
        playback = 1'b1;

        configure(3'b000, -1, -1, -1, 0);
        send(-12'sd5);
        wait_ready(50, lat, val);
        check("byp_lat", lat, 5);
        check("byp_val", val, -5);
        check("byp_starts", start_log.size(), 0);

        configure(3'b001, 1, -1, -1, 0);
        resp_const[0] = 12'd100;
        send(12'sd7);
        wait_ready(50, lat, val);
        check("s0_lat", lat, 7);
        check("s0_val", val, 100);
        check("s0_nstart", start_log.size(), 1);
        if (start_log.size() == 1) begin
            check("s0_start_idx", start_log[0], 0);
            check("s0_start_cyc", start_cyc_log[0], 2);
        end

        configure(3'b111, 1, 1, 1, 1);
        send(12'sd10);
        wait_ready(50, lat, val);
        check("all_lat", lat, 11);
        check("all_val", val, 19);
        check("all_nstart", start_log.size(), 3);
        if (start_log.size() == 3) begin
            check("all_order0", start_log[0], 0);
            check("all_order1", start_log[1], 1);
            check("all_order2", start_log[2], 2);
        end
        check("all_smp0", seen_sample[0], 10);
        check("all_smp1", seen_sample[1], 11);
        check("all_smp2", seen_sample[2], 22);

        configure(3'b010, -1, -1, -1, 0);
        send(12'sd42);
        wait_ready(700, lat, val);
        check("hang_lat", lat, 517);
        check("hang_val", val, 42);
        check("hang_fault", int'(stage_fault), 2);
        clear_status = 1'b1;
        @(negedge clock);
        clear_status = 1'b0;
        check("hang_clear", int'(stage_fault), 0);

        configure(3'b001, TO - 1, -1, -1, 0);
        resp_const[0] = 12'd77;
        send(12'sd3);
        wait_ready(700, lat, val);
        check("edge_lat", lat, 517);
        check("edge_val", val, 77);
        check("edge_fault", int'(stage_fault), 0);

        configure(3'b001, TO, -1, -1, 0);
        send(12'sd3);
        wait_ready(700, lat, val);
        check("late_lat", lat, 517);
        check("late_val", val, 3);
        check("late_fault", int'(stage_fault), 1);
        repeat (3) @(negedge clock);
        check("late_busy", int'(busy), 0);
        clear_status = 1'b1;
        @(negedge clock);
        clear_status = 1'b0;

        configure(3'b001, 310, -1, -1, 0);
        resp_const[0] = 12'd55;
        send(12'sd9);
        pulses = 0;
        for (int k = 0; k < 300; k++) begin
            new_sample_ready = 1'b1;
            samples_in = 12'd1000;
            pulses++;
            @(negedge clock);
        end
        new_sample_ready = 1'b0;
        check("ovr_pulses", pulses, 300);
        wait_ready(100, lat, val);
        check("ovr_lat", lat, 316);
        check("ovr_val", val, 55);
        check("ovr_count", int'(overrun_count), 255);

        configure(3'b000, -1, -1, -1, 0);
        send(12'sd1);
        new_sample_ready = 1'b1;
        clear_status = 1'b1;
        @(negedge clock);
        new_sample_ready = 1'b0;
        clear_status = 1'b0;
        check("ovr_clear", int'(overrun_count), 0);
        wait_ready(50, lat, val);
        check("ovr_clear_val", val, 1);

        configure(3'b001, -1, -1, -1, 0);
        send(12'sd5);
        @(negedge clock);
        @(negedge clock);
        check("rstw_busy_pre", int'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rstw_busy", int'(busy), 0);
        check("rstw_ready", int'(sample_ready), 0);
        check("rstw_start", int'(stage_start), 0);
        start_log.delete();
        @(posedge clock);
        #1 force_done = 3'b001;
        @(posedge clock);
        @(posedge clock);
        #1 force_done = '0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (sample_ready || busy) pulses++;
        end
        check("rstw_stray", pulses, 0);
        check("rstw_nstart", start_log.size(), 0);
        check("rstw_out", int'(sample_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : global_limit
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
